// File: rtl/mips_hazard_pkg.sv
// mips_hazard_pkg: opcodes, instruction field positions and scoreboard entry type
package mips_hazard_pkg;
    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam int RS_LO = 21;
    localparam int RT_LO = 16;
    localparam int RD_LO = 11;
    typedef struct packed {
        logic       valid;
        logic [4:0] dest;
        logic       is_load;
    } sb_entry_t;
endpackage

// File: rtl/hazard_scoreboard.sv
// hazard_scoreboard: EX/MEM/WB in-flight writer shift register with per-stage source match
module hazard_scoreboard
    import mips_hazard_pkg::*;
(
    input  logic      clock,
    input  logic      reset,
    input  sb_entry_t entry,
    input  logic [4:0] rs,
    input  logic [4:0] rt,
    input  logic      rs_used,
    input  logic      rt_used,
    output logic      match_ex,
    output logic      match_mem,
    output logic      match_wb,
    output logic      load_ex
);
    sb_entry_t sb_ex, sb_mem, sb_wb;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            sb_ex  <= '0;
            sb_mem <= '0;
            sb_wb  <= '0;
        end else begin
            sb_ex  <= entry;
            sb_mem <= sb_ex;
            sb_wb  <= sb_mem;
        end
    end

    function automatic logic hit(sb_entry_t e, logic [4:0] r, logic used);
        return used && r != 5'd0 && e.valid && e.dest == r;
    endfunction

    assign match_ex  = hit(sb_ex, rs, rs_used)  | hit(sb_ex, rt, rt_used);
    assign match_mem = hit(sb_mem, rs, rs_used) | hit(sb_mem, rt, rt_used);
    assign match_wb  = hit(sb_wb, rs, rs_used)  | hit(sb_wb, rt, rt_used);
    assign load_ex   = sb_ex.valid & sb_ex.is_load;
endmodule

// File: rtl/hazard_stall_controller.sv
// hazard_stall_controller: decode-stage stall/bubble/flush generation with saturating event counters
// Define HAZARD_FORWARDING_EN to model EX/MEM and MEM/WB forwarding (load-use stalls only).
module hazard_stall_controller
    import mips_hazard_pkg::*;
#(
    parameter bit RF_WRITE_THROUGH = 1'b1,
    parameter int CNT_W            = 16
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [31:0]      ip_instruction,
    input  logic             ip_R_format,
    input  logic             ip_I_format,
    input  logic             ip_Lw,
    input  logic             ip_Sw,
    input  logic             ip_Beq,
    input  logic             ip_branch_taken,
    output logic             op_stall,
    output logic             op_bubble,
    output logic             op_flush,
    output logic [CNT_W-1:0] op_stall_count,
    output logic [CNT_W-1:0] op_flush_count
);
`ifdef HAZARD_FORWARDING_EN
    localparam bit FWD = 1'b1;
`else
    localparam bit FWD = 1'b0;
`endif

    logic       nop, writer, hz;
    logic       match_ex, match_mem, match_wb, load_ex;
    logic [4:0] rs, rt, rd, dest;
    sb_entry_t  entry;

    assign nop    = ip_instruction == 32'd0;
    assign rs     = ip_instruction[RS_LO+:5];
    assign rt     = ip_instruction[RT_LO+:5];
    assign rd     = ip_instruction[RD_LO+:5];
    assign writer = (ip_R_format | ip_Lw) & ~nop;
    assign dest   = ip_R_format ? rd : rt;
    // A stalled or squashed ID instruction must not enter the scoreboard
    assign entry  = '{valid:   writer & (dest != 5'd0) & ~(op_stall | op_flush),
                      dest:    dest,
                      is_load: ip_Lw};

    hazard_scoreboard u_sb (
        .clock     (clock),
        .reset     (reset),
        .entry     (entry),
        .rs        (rs),
        .rt        (rt),
        .rs_used   (~nop & (ip_R_format | ip_I_format | ip_Lw | ip_Sw | ip_Beq)),
        .rt_used   (~nop & (ip_R_format | ip_Sw | ip_Beq)),
        .match_ex  (match_ex),
        .match_mem (match_mem),
        .match_wb  (match_wb),
        .load_ex   (load_ex)
    );

    assign hz        = FWD ? (match_ex & load_ex)
                           : (match_ex | match_mem | (~RF_WRITE_THROUGH & match_wb));
    assign op_flush  = reset & ip_branch_taken;
    assign op_stall  = reset & hz & ~ip_branch_taken;
    assign op_bubble = op_stall | op_flush;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            op_stall_count <= '0;
            op_flush_count <= '0;
        end else begin
            if (op_stall && op_stall_count != '1) op_stall_count <= op_stall_count + 1'b1;
            if (op_flush && op_flush_count != '1) op_flush_count <= op_flush_count + 1'b1;
        end
    end
endmodule

// File: tb/tb_hazard_stall_controller.sv
// tb_hazard_stall_controller: directed and random checks against a pipeline-age reference model
module tb_hazard_stall_controller;
    localparam bit RFWT = 1'b1;
    localparam int CW   = 4;
    localparam int CMAX = (1 << CW) - 1;
`ifdef HAZARD_FORWARDING_EN
    localparam bit FWD = 1'b1;
`else
    localparam bit FWD = 1'b0;
`endif
    localparam logic [4:0] F_R = 5'b10000, F_I = 5'b01000, F_LW = 5'b00100, F_SW = 5'b00010, F_BEQ = 5'b00001;

    logic          clock = 1'b0;
    logic          reset = 1'b0;
    logic [31:0]   ins = '0;
    logic          fr = 0, fi = 0, flw = 0, fsw = 0, fbeq = 0, bt = 0;
    logic          stall, bubble, flush;
    logic [CW-1:0] sc, fc;

    int vectors = 0, miscompares = 0;
    int hd[3];
    bit hl[3];
    int m_sc, m_fc;

    hazard_stall_controller #(.RF_WRITE_THROUGH(RFWT), .CNT_W(CW)) dut (
        .clock(clock), .reset(reset), .ip_instruction(ins),
        .ip_R_format(fr), .ip_I_format(fi), .ip_Lw(flw), .ip_Sw(fsw), .ip_Beq(fbeq),
        .ip_branch_taken(bt), .op_stall(stall), .op_bubble(bubble), .op_flush(flush),
        .op_stall_count(sc), .op_flush_count(fc)
    );

    always #5 clock = ~clock;

    function automatic logic [31:0] r_ins(int d, int s, int t);
        return {6'h00, s[4:0], t[4:0], d[4:0], 5'd0, 6'h20};
    endfunction
    function automatic logic [31:0] i_ins(logic [5:0] op, int s, int t, int imm);
        return {op, s[4:0], t[4:0], imm[15:0]};
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        assert (got === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic model_clear();
        for (int a = 0; a < 3; a++) begin hd[a] = 0; hl[a] = 0; end
        m_sc = 0;
        m_fc = 0;
    endtask

    // One decode cycle: present inputs, compare against the ages of earlier writers, advance model
    task automatic cyc(input logic [31:0] in_i, input logic [4:0] fl, input logic b, output logic st);
        int  rs, rt, rd, d;
        bit  nop, use_rs, use_rt, hz, win, es, wr;
        @(negedge clock);
        ins = in_i;
        {fr, fi, flw, fsw, fbeq} = fl;
        bt = b;
        #1;
        rs = int'(in_i[25:21]); rt = int'(in_i[20:16]); rd = int'(in_i[15:11]);
        nop = (in_i == 0);
        use_rs = !nop && fl != 0;
        use_rt = !nop && (fl[4] || fl[1] || fl[0]);
        hz = 0;
        for (int a = 0; a < 3; a++) begin
            win = FWD ? (a == 0 && hl[a]) : (a < (RFWT ? 2 : 3));
            if (hd[a] != 0 && win && ((use_rs && rs == hd[a]) || (use_rt && rt == hd[a]))) hz = 1;
        end
        es = hz && !b;
        check("stall", stall, es);
        check("flush", flush, b);
        check("bubble", bubble, es || b);
        check("stall_count", sc, m_sc);
        check("flush_count", fc, m_fc);
        wr = !nop && (fl[4] || fl[2]);
        d  = fl[4] ? rd : rt;
        hd[2] = hd[1]; hl[2] = hl[1];
        hd[1] = hd[0]; hl[1] = hl[0];
        hd[0] = (wr && !es && !b) ? d : 0;
        hl[0] = fl[2];
        if (es && m_sc < CMAX) m_sc++;
        if (b && m_fc < CMAX) m_fc++;
        st = es;
    endtask

    // Present an instruction until it is no longer stalled; returns number of stall cycles
    task automatic issue(input logic [31:0] in_i, input logic [4:0] fl, output int n);
        logic st;
        n = 0;
        for (int k = 0; k < 6; k++) begin
            cyc(in_i, fl, 1'b0, st);
            if (!st) return;
            n++;
        end
        check("stall_bound", 32'(n), 32'd5);
    endtask

    task automatic drain();
        logic st;
        repeat (3) cyc(32'd0, F_R, 1'b0, st);
    endtask

    task automatic do_reset();
        @(negedge clock);
        #1 reset = 1'b0;
        bt = 1'b1;
        #1;
        check("rst_stall", stall, 1'b0);
        check("rst_flush", flush, 1'b0);
        check("rst_bubble", bubble, 1'b0);
        check("rst_scnt", sc, 0);
        check("rst_fcnt", fc, 0);
        bt = 1'b0;
        model_clear();
        #1 reset = 1'b1;
    endtask

    initial begin : main
        int          n;
        logic        st;
        logic [31:0] cur;
        logic [4:0]  cfl;
        int          kind, ra, rb, rc;
        model_clear();
        do_reset();
        // RAW through the register file
        issue(r_ins(3, 1, 2), F_R, n);
        issue(r_ins(4, 3, 1), F_R, n);
        check("raw_stalls", n, FWD ? 0 : (RFWT ? 2 : 3));
        check("raw_count", sc, FWD ? 0 : (RFWT ? 2 : 3));
        drain();
        // load-use
        issue(i_ins(6'h23, 1, 5, 0), F_LW, n);
        issue(r_ins(6, 5, 5), F_R, n);
        check("load_use", n, FWD ? 1 : (RFWT ? 2 : 3));
        drain();
        // register 0 and NOP
        issue(r_ins(0, 1, 2), F_R, n);
        issue(r_ins(4, 0, 0), F_R, n);
        check("reg0", n, 0);
        issue(32'd0, F_R, n);
        issue(r_ins(9, 0, 0), F_R, n);
        check("nop", n, 0);
        drain();
        // store and branch sources
        issue(i_ins(6'h23, 1, 7, 0), F_LW, n);
        issue(i_ins(6'h2b, 2, 7, 4), F_SW, n);
        check("sw_src", n, FWD ? 1 : (RFWT ? 2 : 3));
        drain();
        issue(r_ins(8, 1, 2), F_R, n);
        issue(i_ins(6'h04, 8, 1, 3), F_BEQ, n);
        check("beq_src", n, FWD ? 0 : (RFWT ? 2 : 3));
        drain();
        // flush beats stall, squashed writer never recorded
        do_reset();
        issue(i_ins(6'h23, 1, 3, 0), F_LW, n);
        cyc(r_ins(4, 3, 1), F_R, 1'b1, st);
        check("flush_pri_stall", stall, 1'b0);
        check("flush_pri_bubble", bubble, 1'b1);
        issue(r_ins(5, 4, 4), F_R, n);
        check("flush_no_entry", n, 0);
        check("flush_count", fc, 1);
        drain();
        // reset in the middle of a stall
        issue(r_ins(3, 1, 2), F_R, n);
        cyc(r_ins(4, 3, 1), F_R, 1'b0, st);
        check("pre_rst_stall", st, FWD ? 1'b0 : 1'b1);
        do_reset();
        issue(r_ins(4, 3, 1), F_R, n);
        check("post_rst_nostall", n, 0);
        // flush counter saturation
        repeat (CMAX + 4) cyc(32'd0, F_R, 1'b1, st);
        cyc(32'd0, F_R, 1'b0, st);
        check("flush_sat", fc, CMAX);
        // random traffic
        do_reset();
        cur = '0; cfl = F_R; st = 0;
        for (int k = 0; k < 600; k++) begin
            if (!st || $urandom_range(0, 3) == 0) begin
                kind = $urandom_range(0, 5);
                ra = $urandom_range(0, 7); rb = $urandom_range(0, 7); rc = $urandom_range(0, 7);
                case (kind)
                    0: begin cur = r_ins(ra, rb, rc); cfl = F_R; end
                    1: begin cur = i_ins(6'h23, rb, ra, 8); cfl = F_LW; end
                    2: begin cur = i_ins(6'h2b, rb, ra, 4); cfl = F_SW; end
                    3: begin cur = i_ins(6'h04, rb, ra, 2); cfl = F_BEQ; end
                    4: begin cur = i_ins(6'h08, rb, ra, 1); cfl = F_I; end
                    default: begin cur = 32'd0; cfl = F_R; end
                endcase
            end
            if ($urandom_range(0, 149) == 0) do_reset();
            cyc(cur, cfl, $urandom_range(0, 7) == 0, st);
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/hazard_stall_controller.md
Name: hazard_stall_controller

Overview:
- Decode-stage hazard and stall controller for the 5-stage MIPS pipeline.
- Consumes the decode-stage instruction and the format flags from the control unit (R_format, I_format, Lw, Sw, Beq), plus the EXE branch outcome.
- Tracks in-flight register writers in a 3-entry scoreboard for EX, MEM and WB.
- Drives stall (hold PC and IF/ID), bubble (zero the ID/EX controls) and flush (squash wrong-path fetches).

Parameters:
- RF_WRITE_THROUGH, 1, 1 = register file writes in the first half-cycle and reads in the second, so a WB-stage writer causes no hazard; 0 = WB writer also stalls.
- CNT_W, 16, width of the saturating performance counters.

Ports:
- clock  in  1  pipeline clock, rising edge
- reset  in  1  asynchronous, active-low
- ip_instruction  in  32  instruction in ID
- ip_R_format, ip_I_format, ip_Lw, ip_Sw, ip_Beq  in  1 each  decode flags from the control unit
- ip_branch_taken  in  1  EXE branch AND zero; valid one cycle
- op_stall  out  1  hold PC and IF/ID
- op_bubble  out  1  force the ID/EX control register to all-zero
- op_flush  out  1  squash IF/ID (load NOP)
- op_stall_count  out  CNT_W  cycles with op_stall=1, saturating
- op_flush_count  out  CNT_W  cycles with op_flush=1, saturating

Behaviour:
- Reset (reset=0, async): all scoreboard entries invalid; counters 0; op_stall/op_bubble/op_flush forced to 0 while reset is low.
- Decode:
  - rs=[25:21], rt=[20:16], rd=[15:11]; NOP = instruction==0.
  - Writer = (R_format|Lw) & ~NOP. Dest = rd if R_format, rt if Lw.
  - A dest of 0 is never recorded as valid.
- Sources:
  - rs is used by R_format, I_format, Lw, Sw, Beq.
  - rt is used by R_format, Sw, Beq.
  - NOP uses no sources. Register 0 never matches.
- Scoreboard:
  - Entries sb_EX, sb_MEM, sb_WB, each {valid, dest[4:0], is_load}.
  - Every clock: sb_WB<=sb_MEM, sb_MEM<=sb_EX.
  - sb_EX <= decoded writer, or invalid if op_stall|op_flush is high that cycle.
- Hazard (no forwarding): hz = a source matches a valid dest in sb_EX or sb_MEM, or in sb_WB when RF_WRITE_THROUGH=0.
- Outputs (combinational from registered scoreboard plus ID inputs; zero-latency):
  - op_flush = ip_branch_taken.
  - op_stall = hz & ~op_flush.
  - op_bubble = op_stall | op_flush.
- Priority: flush beats stall. On a taken branch the stalled ID instruction is wrong-path and is discarded; no stall is asserted that cycle.
- A stall persists until the writer leaves the hazard window. Max 2 cycles with RF_WRITE_THROUGH=1, 3 with 0.
- Back-to-back hazards: each ID instruction is evaluated independently every cycle; no stall state is carried beyond the scoreboard.
- Counters: increment on the clock edge after the flag is high; hold at 2^CNT_W-1.
- Reset mid-stall: scoreboard clears immediately and the stall drops asynchronously.

Optional Feature:
- Macro: HAZARD_FORWARDING_EN.
- Defined: the EX/MEM and MEM/WB forwarding paths exist. hz = a source matches sb_EX.dest with sb_EX.valid & sb_EX.is_load (load-use only), giving exactly 1 stall cycle. MEM/WB entries never stall.
- Undefined: the full hazard rule above applies. is_load is still tracked but unused.

Decomposition:
- Package mips_hazard_pkg:
  - opcode constants (OP_RTYPE 6'b000000, OP_LW 6'b100011, OP_SW 6'b101011, OP_BEQ 6'b000100)
  - field-position constants
  - typedef struct sb_entry_t {valid, dest, is_load}
- Sub-module hazard_scoreboard: the 3-stage shift register plus the per-source match logic. Returns match_EX/match_MEM/match_WB and load_EX.
- The top level holds the priority logic and the counters.

Test Plan:
- Reset: drive reset=0 mid-stall -> stall/bubble/flush=0 immediately; counters=0 after release.
- RAW, no forwarding, RF_WRITE_THROUGH=1: add $3,$1,$2 then add $4,$3,$1 -> op_stall=1 for 2 cycles, op_stall_count=2, the second add proceeds on cycle 3.
- Load-use: lw $5,0($1) then add $6,$5,$5 -> 1 stall cycle with HAZARD_FORWARDING_EN, 2 without.
- Register 0 and NOP: add $0,$1,$2 then add $4,$0,$0, and 32'h00000000 in ID -> no stall, no scoreboard entry.
- Flush priority: hazard pending and ip_branch_taken=1 same cycle -> op_flush=1, op_stall=0, op_bubble=1, sb_EX invalid next cycle, op_flush_count=1.
- Sw/Beq sources: lw $7 then sw $7,4($2), and add $8 then beq $8,$1 -> stalls exactly as in the RAW case; RF_WRITE_THROUGH=0 extends each case by one cycle.
